// File: rtl/chnl_tx_pkg.sv
// Shared types and helpers for the CHNL transmitter.
package chnl_tx_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_SEND = 2'd2
  } state_t;

  function automatic int beats_of(input int tx_len, input int pci_width);
    return tx_len / (pci_width / 32);
  endfunction

endpackage

// File: rtl/chnl_tx_repack.sv
// Width repacker: gathers/splits IN lanes into OUT lanes of W bits, first lane lowest.
// Latency: output valid the cycle after the completing input; i_rdy drops when IN lanes no longer fit.
module chnl_tx_repack #(
  parameter int IN  = 1,
  parameter int OUT = 2,
  parameter int W   = 32
) (
  input  logic              clk,
  input  logic              rst_ni,
  input  logic              i_val,
  output logic              i_rdy,
  input  logic [IN*W-1:0]   i_data,
  output logic              o_val,
  input  logic              o_rdy,
  output logic [OUT*W-1:0]  o_data
);

  localparam int CAP = IN + OUT;
  localparam int BW  = CAP * W;
  localparam int CW  = $clog2(CAP + 1);

  logic [BW-1:0] buf_q, buf_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          push, pop;
  int            sh;

  assign i_rdy  = (cnt_q <= CW'(CAP - IN));
  assign o_val  = (cnt_q >= CW'(OUT));
  assign o_data = buf_q[OUT*W-1:0];
  assign push   = i_val && i_rdy;
  assign pop    = o_val && o_rdy;

  // Lanes above cnt_q are kept zero so new words can be OR-ed in place.
  always_comb begin
    buf_d = buf_q;
    cnt_d = cnt_q;
    sh    = 0;
    if (pop) begin
      buf_d = buf_q >> (OUT * W);
      cnt_d = cnt_q - CW'(OUT);
    end
    if (push) begin
      sh    = int'(cnt_d) * W;
      buf_d = buf_d | (BW'(i_data) << sh);
      cnt_d = cnt_d + CW'(IN);
    end
  end

  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      buf_q <= '0;
      cnt_q <= '0;
    end else begin
      buf_q <= buf_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/chnl_tx_slice.sv
// Single-entry register slice; one cycle latency.
// Accepts a new word whenever empty or being drained the same cycle.
module chnl_tx_slice #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst_ni,
  input  logic             i_val,
  output logic             i_rdy,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_val,
  input  logic             o_rdy,
  output logic [WIDTH-1:0] o_data
);

  assign i_rdy = !o_val || o_rdy;

  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      o_val  <= 1'b0;
      o_data <= '0;
    end else if (i_rdy) begin
      o_val <= i_val;
      if (i_val) o_data <= i_data;
    end
  end

endmodule

// File: rtl/chnl_tx.sv
// Riffa CHNL transmitter: repacks a valid/ready stream into fixed TX_LEN-dword host transactions.
// Latency: repacker + slice register + request/ACK round trip; i_rdy follows repacker backpressure.
module chnl_tx
  import chnl_tx_pkg::*;
#(
  parameter int C_PCI_DATA_WIDTH = 32,
  parameter int TX_WIDTH         = 32,
  parameter int GCD              = 32,
  parameter int TX_LEN           = 1024
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        i_val,
  output logic                        i_rdy,
  input  logic [TX_WIDTH-1:0]         i_data,
  output logic                        CHNL_TX_CLK,
  output logic                        CHNL_TX,
  input  logic                        CHNL_TX_ACK,
  output logic                        CHNL_TX_LAST,
  output logic [31:0]                 CHNL_TX_LEN,
  output logic [30:0]                 CHNL_TX_OFF,
  output logic [C_PCI_DATA_WIDTH-1:0] CHNL_TX_DATA,
  output logic                        CHNL_TX_DATA_VALID,
  input  logic                        CHNL_TX_DATA_REN
);

  localparam int BEATS = beats_of(TX_LEN, C_PCI_DATA_WIDTH);

  logic                        rst_n;
  logic                        rp_val, rp_rdy;
  logic [C_PCI_DATA_WIDTH-1:0] rp_data;
  logic                        sl_val, sl_rdy;
  logic [C_PCI_DATA_WIDTH-1:0] sl_data;

  state_t      state_q, state_d;
  logic [31:0] cnt_left_q, cnt_left_d;

  assign rst_n        = ~rst;
  assign CHNL_TX_CLK  = clk;
  assign CHNL_TX_LAST = 1'b1;
  assign CHNL_TX_LEN  = 32'(TX_LEN);
  assign CHNL_TX_OFF  = '0;
  assign CHNL_TX_DATA = sl_data;

  chnl_tx_repack #(
    .IN  (TX_WIDTH / GCD),
    .OUT (C_PCI_DATA_WIDTH / GCD),
    .W   (GCD)
  ) u_repack (
    .clk    (clk),
    .rst_ni (rst_n),
    .i_val  (i_val),
    .i_rdy  (i_rdy),
    .i_data (i_data),
    .o_val  (rp_val),
    .o_rdy  (rp_rdy),
    .o_data (rp_data)
  );

  chnl_tx_slice #(
    .WIDTH (C_PCI_DATA_WIDTH)
  ) u_slice (
    .clk    (clk),
    .rst_ni (rst_n),
    .i_val  (rp_val),
    .i_rdy  (rp_rdy),
    .i_data (rp_data),
    .o_val  (sl_val),
    .o_rdy  (sl_rdy),
    .o_data (sl_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_left_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_left_q <= cnt_left_d;
    end
  end

  // The slice only drains during S_SEND, so a request always has data behind it.
  always_comb begin
    state_d            = state_q;
    cnt_left_d         = cnt_left_q;
    CHNL_TX            = 1'b0;
    CHNL_TX_DATA_VALID = 1'b0;
    sl_rdy             = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (sl_val) begin
          state_d    = S_REQ;
          cnt_left_d = 32'(BEATS);
        end
      end
      S_REQ: begin
        CHNL_TX = 1'b1;
        if (CHNL_TX_ACK) state_d = S_SEND;
      end
      S_SEND: begin
        CHNL_TX            = 1'b1;
        CHNL_TX_DATA_VALID = sl_val;
        sl_rdy             = CHNL_TX_DATA_REN;
        if (sl_val && CHNL_TX_DATA_REN) begin
          cnt_left_d = cnt_left_q - 32'd1;
          if (cnt_left_q == 32'd1) state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule
